pe_chain_ctrl: RTL and testbench

Sequencer for a 1-D systolic chain of `N` PEs. In the chain, operands (`i_in`/`i_w`) enter PE0 and advance one PE per cycle. Each PE's `o_out` feeds the next PE's `i_out`, and the last PE's `o_out` is the chain result.

The block drives each PE's 2-bit `ctl` code and gates the operand feeders so that one dot product of programmable length is computed per PE per job. It then drains the N results out of the tail of the chain, one per cycle, with an index strobe. It sits between the layer scheduler (`start`/`done`) and the PE chain plus its input feeders.

PE `ctl` codes:
- 0 = clear buffer
- 1 = accumulate and drive own buffer on `o_out`
- 2 = accumulate and pass `i_out` through to `o_out`

---
 rtl/pe_chain_ctrl_if.sv | 42 ++++
 rtl/pe_chain_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pe_chain_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_chain_ctrl_if.sv
// ----------------------------------------------------------------------------
// pe_chain_ctrl_if
// Groups the scheduler-facing job handshake and the PE-chain control outputs
// of pe_chain_ctrl into one bundle.
//
//   start     scheduler -> ctrl   job request (sampled only while idle)
//   len       scheduler -> ctrl   MAC terms per result, latched on start
//   abort     scheduler -> ctrl   synchronous job cancel
//   busy      ctrl -> scheduler   job in progress
//   done      ctrl -> scheduler   one-cycle completion pulse
//   feed_en   ctrl -> feeders     present operands to PE0 (zeros when low)
//   ctl_bus   ctrl -> PE chain    2-bit ctl per PE, PE j on [2j+1:2j]
//   out_valid ctrl -> consumer    chain tail carries a result this cycle
//   out_idx   ctrl -> consumer    PE index of that result
//
// master: the scheduler / consumer side.  slave: the controller.
// ----------------------------------------------------------------------------
interface pe_chain_ctrl_if #(
    parameter int N    = 4,
    parameter int IDXW = 2,
    parameter int LENW = 8
);
    logic              start;
    logic [LENW-1:0]   len;
    logic              abort;
    logic              busy;
    logic              done;
    logic              feed_en;
    logic [2*N-1:0]    ctl_bus;
    logic              out_valid;
    logic [IDXW-1:0]   out_idx;

    modport master (
        output start, len, abort,
        input  busy, done, feed_en, ctl_bus, out_valid, out_idx
    );

    modport slave (
        input  start, len, abort,
        output busy, done, feed_en, ctl_bus, out_valid, out_idx
    );
endinterface

// File: rtl/pe_chain_ctrl.sv
// ----------------------------------------------------------------------------
// pe_chain_ctrl
// Sequencer for a 1-D systolic chain of N PEs. For each job it clears the PE
// buffers, streams len operand pairs into PE0, flushes the skewed operands to
// the chain tail, then drains the N per-PE results out of the tail one per
// cycle with an index strobe, and finally pulses done.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   pe_chain_ctrl_if.slave (start/len/abort in; busy/done/feed_en/
//         ctl_bus/out_valid/out_idx out). All outputs are registered.
// ----------------------------------------------------------------------------
module pe_chain_ctrl #(
    parameter int N    = 4,
    parameter int IDXW = 2,
    parameter int LENW = 8
) (
    input  logic           clk,
    input  logic           rst,
    pe_chain_ctrl_if.slave bus
);

    // Flush/drain counter must hold values up to N.
    localparam int CW = $clog2(N + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CW-1:0]   FLUSH_LAST = CW'(N - 2);
    localparam logic [CW-1:0]   DRAIN_LAST = CW'(N - 1);
    localparam logic [LENW-1:0] RUN_LAST   = LENW'(1);

    localparam logic [1:0] CTL_CLEAR = 2'd0;
    localparam logic [1:0] CTL_OWN   = 2'd1;
    localparam logic [1:0] CTL_PASS  = 2'd2;

    logic [2:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [LENW-1:0]  r_run_cnt;

    logic             r_busy;
    logic             r_done;
    logic             r_feed_en;
    logic [2*N-1:0]   r_ctl;
    logic             r_out_valid;
    logic [IDXW-1:0]  r_out_idx;

    logic [2:0]       w_nxt_state;
    logic [CW-1:0]    w_nxt_cnt;
    logic [LENW-1:0]  w_nxt_run;
    logic [2*N-1:0]   w_nxt_ctl;

    // Next-state and counter logic.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_run   = r_run_cnt;
        case (r_state)
            S_IDLE: begin
                if (!bus.abort && bus.start && (bus.len != '0)) begin
                    w_nxt_state = S_CLEAR;
                    w_nxt_run   = bus.len;
                    w_nxt_cnt   = '0;
                end
            end
            S_CLEAR: begin
                w_nxt_state = S_RUN;
            end
            S_RUN: begin
                // Count the latched length down; it never wraps because len
                // is non-zero on entry and RUN exits when it reaches 1.
                if (r_run_cnt != '0) begin
                    w_nxt_run = r_run_cnt - LENW'(1);
                end
                if (r_run_cnt <= RUN_LAST) begin
                    w_nxt_state = S_FLUSH;
                    w_nxt_cnt   = '0;
                end
            end
            S_FLUSH: begin
                if (r_cnt == FLUSH_LAST) begin
                    w_nxt_state = S_DRAIN;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + CW'(1);
                end
            end
            S_DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_nxt_state = S_DONE;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + CW'(1);
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
                w_nxt_run   = '0;
            end
        endcase

        if (bus.abort && (r_state != S_IDLE)) begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = '0;
            w_nxt_run   = '0;
        end
    end

    // Per-PE ctl for the state being entered. During DRAIN, PEs ahead of the
    // drain index are already emptied (clear), the indexed PE drives its
    // buffer, and PEs behind it pass that value down the chain; they only see
    // zero operands by now, so their buffers are preserved.
    always_comb begin
        w_nxt_ctl = '0;
        for (int j = 0; j < N; j++) begin
            case (w_nxt_state)
                S_RUN, S_FLUSH: w_nxt_ctl[2*j +: 2] = CTL_PASS;
                S_DRAIN: begin
                    if (CW'(j) < w_nxt_cnt) begin
                        w_nxt_ctl[2*j +: 2] = CTL_CLEAR;
                    end else if (CW'(j) == w_nxt_cnt) begin
                        w_nxt_ctl[2*j +: 2] = CTL_OWN;
                    end else begin
                        w_nxt_ctl[2*j +: 2] = CTL_PASS;
                    end
                end
                default: w_nxt_ctl[2*j +: 2] = CTL_CLEAR;
            endcase
        end
    end

    // Register stage: outputs are decoded from the next state so they change
    // on the same edge as the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_run_cnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_feed_en   <= 1'b0;
            r_ctl       <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_run_cnt   <= w_nxt_run;
            r_busy      <= (w_nxt_state != S_IDLE);
            r_done      <= (w_nxt_state == S_DONE);
            r_feed_en   <= (w_nxt_state == S_RUN);
            r_ctl       <= w_nxt_ctl;
            r_out_valid <= (w_nxt_state == S_DRAIN);
            r_out_idx   <= (w_nxt_state == S_DRAIN) ? IDXW'(w_nxt_cnt) : '0;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.feed_en   = r_feed_en;
    assign bus.ctl_bus   = r_ctl;
    assign bus.out_valid = r_out_valid;
    assign bus.out_idx   = r_out_idx;

endmodule

// File: tb/tb_pe_chain_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pe_chain_ctrl
// Drives pe_chain_ctrl through its job sequences and models a PE chain plus
// operand feeder around it. Each model PE j scales its products by (j+1) so
// that the drained results differ per PE. Expected results are pushed to a
// queue when a job is started and compared as the chain tail produces them.
// ----------------------------------------------------------------------------
module tb_pe_chain_ctrl;
    localparam int N    = 4;
    localparam int IDXW = 2;
    localparam int LENW = 8;

    logic clk;
    logic rst;

    pe_chain_ctrl_if #(.N(N), .IDXW(IDXW), .LENW(LENW)) bus ();

    pe_chain_ctrl #(.N(N), .IDXW(IDXW), .LENW(LENW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- operand feeder and PE chain model ----------------
    logic signed [7:0]  a_vec [256];
    logic signed [7:0]  w_vec [256];
    logic [8:0]         fidx;
    logic signed [31:0] pe_buf [N];
    logic signed [31:0] a_r [N];
    logic signed [31:0] w_r [N];
    logic signed [31:0] a_in [N];
    logic signed [31:0] w_in [N];
    logic signed [31:0] chain_out;

    always_comb begin
        for (int j = 0; j < N; j++) begin
            if (j == 0) begin
                a_in[j] = bus.feed_en ? 32'(a_vec[fidx[7:0]]) : 32'sd0;
                w_in[j] = bus.feed_en ? 32'(w_vec[fidx[7:0]]) : 32'sd0;
            end else begin
                a_in[j] = a_r[j-1];
                w_in[j] = w_r[j-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!bus.busy) fidx <= '0;
        else if (bus.feed_en) fidx <= fidx + 9'd1;
        for (int j = 0; j < N; j++) begin
            if (bus.ctl_bus[2*j +: 2] == 2'd0) begin
                pe_buf[j] <= 32'sd0;
                a_r[j]    <= 32'sd0;
                w_r[j]    <= 32'sd0;
            end else begin
                pe_buf[j] <= pe_buf[j] + a_in[j] * w_in[j] * (j + 1);
                a_r[j]    <= a_in[j];
                w_r[j]    <= w_in[j];
            end
        end
    end

    always_comb begin
        chain_out = 32'sd0;
        for (int j = 0; j < N; j++) begin
            case (bus.ctl_bus[2*j +: 2])
                2'd1:    chain_out = pe_buf[j];
                2'd2:    chain_out = chain_out;
                default: chain_out = 32'sd0;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { int idx; int val; } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    task automatic fill_ops();
        for (int i = 0; i < 256; i++) begin
            a_vec[i] = 8'($urandom);
            w_vec[i] = 8'($urandom);
        end
    endtask

    task automatic push_job(input int len_v);
        int s;
        sb_t e;
        s = 0;
        for (int i = 0; i < len_v; i++) s += int'(a_vec[i]) * int'(w_vec[i]);
        for (int j = 0; j < N; j++) begin
            e.idx = j;
            e.val = s * (j + 1);
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst && bus.out_valid) begin
            chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                chk("res_idx", 32'(bus.out_idx), mon_e.idx);
                chk($sformatf("res_val_pe%0d", mon_e.idx), chain_out, mon_e.val);
            end
        end
    end

    // ---------------- timeline checks ----------------
    task automatic check_idle(input string tag);
        chk({tag, "_busy"},    32'(bus.busy),      32'd0);
        chk({tag, "_done"},    32'(bus.done),      32'd0);
        chk({tag, "_feed"},    32'(bus.feed_en),   32'd0);
        chk({tag, "_valid"},   32'(bus.out_valid), 32'd0);
        chk({tag, "_idx"},     32'(bus.out_idx),   32'd0);
        chk({tag, "_ctl"},     32'(bus.ctl_bus),   32'd0);
    endtask

    // Expected outputs in cycle Tk of a job with latched length L.
    task automatic check_cycle(input int k, input int L);
        logic [2*N-1:0] ec;
        logic           drain;
        int             d;
        drain = (k >= L + N + 1) && (k <= L + 2*N);
        d     = drain ? (k - L - N - 1) : 0;
        ec    = '0;
        for (int j = 0; j < N; j++) begin
            if (k >= 2 && k <= L + N)  ec[2*j +: 2] = 2'd2;
            else if (drain)            ec[2*j +: 2] = (j < d) ? 2'd0 : ((j == d) ? 2'd1 : 2'd2);
        end
        chk($sformatf("ctl_bus@T%0d", k), 32'(bus.ctl_bus),   32'(ec));
        chk($sformatf("busy@T%0d", k),    32'(bus.busy),      32'(k >= 1 && k <= L + 2*N + 1));
        chk($sformatf("feed_en@T%0d", k), 32'(bus.feed_en),   32'(k >= 2 && k <= L + 1));
        chk($sformatf("done@T%0d", k),    32'(bus.done),      32'(k == L + 2*N + 1));
        chk($sformatf("valid@T%0d", k),   32'(bus.out_valid), 32'(drain));
        chk($sformatf("idx@T%0d", k),     32'(bus.out_idx),   32'(d));
    endtask

    // Job started at the current negedge; checks cycles T1..Tkmax.
    // poke_k: pulse start (len 7) at that cycle. abort_k: raise abort there.
    task automatic run_job(input int L, input int kmax, input int poke_k, input int abort_k);
        fill_ops();
        if (abort_k == 0) push_job(L);
        bus.start = 1'b1;
        bus.len   = LENW'(L);
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            if (abort_k != 0 && k > abort_k) check_idle($sformatf("abort@T%0d", k));
            else check_cycle(k, L);
            if (k == L + N + 3 && abort_k == 0 && L == 3)
                chk("drain_d2_pattern", 32'(bus.ctl_bus), 32'(8'b10_01_00_00));
            if (k == 1) bus.start = 1'b0;
            if (k == poke_k) begin bus.start = 1'b1; bus.len = 8'd7; end
            if (k == poke_k + 1) bus.start = 1'b0;
            if (k == abort_k) bus.abort = 1'b1;
            if (k == abort_k + 1) bus.abort = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.len   = '0;
        bus.abort = 1'b0;
        fidx      = '0;
        #3;
        check_idle("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Basic job, len 3: busy T1..T12, done at T12, then idle.
        run_job(3, 13, 0, 0);
        chk("sb_left_basic", 32'(sb_q.size()), 32'd0);

        // start with len 0 is ignored.
        bus.start = 1'b1;
        bus.len   = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("len0_%0d", i));
        end
        bus.start = 1'b0;

        // abort and start together while idle: abort wins.
        bus.start = 1'b1;
        bus.len   = 8'd3;
        bus.abort = 1'b1;
        @(negedge clk);
        check_idle("abort_start_idle");
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        check_idle("abort_start_idle2");

        // start pulsed during RUN is ignored; original timing holds.
        run_job(5, 2 + 5 + 2*N, 3, 0);
        chk("sb_left_poke", 32'(sb_q.size()), 32'd0);

        // Abort at T5 of a len 3 job: idle from T6, done never seen.
        run_job(3, 20, 0, 5);

        // Reset mid-DRAIN at T9, then a len 1 job right after release.
        fill_ops();
        push_job(3);
        bus.start = 1'b1;
        bus.len   = 8'd3;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_cycle(k, 3);
            if (k == 1) bus.start = 1'b0;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_idle("rst_mid_drain");
        sb_q.delete();
        @(negedge clk);
        check_idle("rst_held");
        @(negedge clk);
        rst = 1'b1;
        run_job(1, 2 + 1 + 2*N, 0, 0);
        chk("sb_left_after_rst", 32'(sb_q.size()), 32'd0);

        // Maximum length with start held: second job (len 4, set while busy)
        // is accepted on the first idle cycle.
        fill_ops();
        push_job(255);
        bus.start = 1'b1;
        bus.len   = 8'd255;
        for (int k = 1; k <= 255 + 2*N + 1; k++) begin
            @(negedge clk);
            check_cycle(k, 255);
            if (k == 2) bus.len = 8'd4;
        end
        @(negedge clk);
        check_idle("b2b_gap");
        chk("sb_left_max", 32'(sb_q.size()), 32'd0);
        push_job(4);
        for (int k = 1; k <= 4 + 2*N + 2; k++) begin
            @(negedge clk);
            check_cycle(k, 4);
            if (k == 1) bus.start = 1'b0;
        end
        chk("sb_left_b2b", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
